dekatron_counter_multistep: RTL and testbench

- Next-generation decimal (BCD) counter for the Dekatron datapath: D_NUM digits, each counting 0..9, with a Request/Ready handshake and a modelled dekatron switching delay.
- Extends the single-step counter with:
  - a multi-step count (N unit steps per request);
  - explicit clear;
  - wrap or saturate mode;
  - overflow and underflow flags.
- Sits in place of the single-step counter for IP/AP registers and loop counters, where multi-digit jumps are needed.

---
 rtl/dekatron_counter_multistep.sv | 104 ++++++++++
 tb/tb_dekatron_counter_multistep.sv | 110 +++++++++++
 2 files changed

// File: rtl/dekatron_counter_multistep.sv
// dekatron_counter_multistep: multi-digit BCD counter with multi-step INC/DEC, SET/CLR, wrap/saturate and a modelled switching delay
// Ports: i_clk/i_rst_n clock and async active-low reset; i_request/i_op/i_steps/i_sat/i_in start and describe an operation;
// o_ready idle flag, o_zero combinational Out==0, o_ovf/o_unf limit flags of the last operation, o_out current BCD value.
module dekatron_counter_multistep #(
  parameter int D_NUM       = 6,
  parameter int D_WIDTH     = 4,
  parameter int WIDTH       = D_NUM * D_WIDTH,
  parameter int COUNT_DELAY = 3,
  parameter int STEP_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_request,
  input  logic [1:0]        i_op,
  input  logic [STEP_W-1:0] i_steps,
  input  logic              i_sat,
  input  logic [WIDTH-1:0]  i_in,
  output logic              o_ready,
  output logic              o_zero,
  output logic              o_ovf,
  output logic              o_unf,
  output logic [WIDTH-1:0]  o_out
);
  localparam int CW = COUNT_DELAY > 1 ? $clog2(COUNT_DELAY) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            r_state;
  logic [1:0]        r_op;
  logic              r_sat, r_ready, r_ovf, r_unf;
  logic [WIDTH-1:0]  r_in, r_out;
  logic [STEP_W-1:0] r_n, r_k;
  logic [CW-1:0]     r_cyc;
  logic [WIDTH-1:0]  w_inc, w_dec, w_clamp;
  logic              w_cin, w_bin, w_all9, w_zero, w_last;
  // Ripple carry/borrow: a digit moves only while every lower digit wraps.
  always_comb begin
    w_cin = 1'b1;
    w_bin = 1'b1;
    w_inc = r_out;
    w_dec = r_out;
    w_clamp = i_in;
    for (int d = 0; d < D_NUM; d++) begin
      w_clamp[d*D_WIDTH +: D_WIDTH] = i_in[d*D_WIDTH +: D_WIDTH] > 4'd9 ? 4'd9 : i_in[d*D_WIDTH +: D_WIDTH];
      w_inc[d*D_WIDTH +: D_WIDTH] = !w_cin ? r_out[d*D_WIDTH +: D_WIDTH] :
        r_out[d*D_WIDTH +: D_WIDTH] == 4'd9 ? 4'd0 : r_out[d*D_WIDTH +: D_WIDTH] + 4'd1;
      w_dec[d*D_WIDTH +: D_WIDTH] = !w_bin ? r_out[d*D_WIDTH +: D_WIDTH] :
        r_out[d*D_WIDTH +: D_WIDTH] == 4'd0 ? 4'd9 : r_out[d*D_WIDTH +: D_WIDTH] - 4'd1;
      w_cin = w_cin && r_out[d*D_WIDTH +: D_WIDTH] == 4'd9;
      w_bin = w_bin && r_out[d*D_WIDTH +: D_WIDTH] == 4'd0;
    end
  end
  assign w_all9  = r_out == {D_NUM{4'h9}};
  assign w_zero  = r_out == '0;
  assign w_last  = r_cyc == CW'(COUNT_DELAY - 1);
  assign o_zero  = w_zero;
  assign o_ready = r_ready;
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;
  assign o_out   = r_out;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_op    <= '0;
      r_sat   <= 1'b0;
      r_in    <= '0;
      r_out   <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_cyc   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (r_state == IDLE) begin
      if (i_request) begin
        r_state <= BUSY;
        r_ready <= 1'b0;
        r_op    <= i_op;
        r_sat   <= i_sat;
        r_in    <= w_clamp;
        // SET/CLR use one window; a zero step count means one step.
        r_n     <= (i_op[1] || i_steps == '0) ? STEP_W'(1) : i_steps;
        r_k     <= STEP_W'(1);
        r_cyc   <= '0;
        r_ovf   <= 1'b0;
        r_unf   <= 1'b0;
      end
    end else begin
      r_cyc <= w_last ? '0 : r_cyc + 1'b1;
      if (w_last) begin
        r_k   <= r_k + 1'b1;
        // Saturated steps still take their window so latency stays fixed.
        r_out <= r_op == 2'b11 ? '0 :
                 r_op == 2'b10 ? r_in :
                 r_op == 2'b00 ? (w_all9 ? (r_sat ? r_out : '0) : w_inc) :
                                 (w_zero ? (r_sat ? r_out : {D_NUM{4'h9}}) : w_dec);
        if (r_op == 2'b00 && w_all9) r_ovf <= 1'b1;
        if (r_op == 2'b01 && w_zero) r_unf <= 1'b1;
        if (r_k == r_n) begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dekatron_counter_multistep.sv
// tb_dekatron_counter_multistep: randomized and directed check of the BCD counter against an integer reference model
module tb_dekatron_counter_multistep;
  localparam int CD = 3;
  logic clk = 1'b0, rst_n = 1'b0, request = 1'b0, sat = 1'b0;
  logic [1:0] op = '0;
  logic [3:0] steps = '0;
  logic [23:0] in = '0, out;
  logic ready, zero, ovf, unf;
  int n_chk = 0, n_fail = 0;
  int mv = 0;
  bit mo = 0, mu = 0;
  dekatron_counter_multistep #(.COUNT_DELAY(CD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(request), .i_op(op), .i_steps(steps),
    .i_sat(sat), .i_in(in), .o_ready(ready), .o_zero(zero), .o_ovf(ovf), .o_unf(unf), .o_out(out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    for (int d = 0; d < 6; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic int clamp_val(input logic [23:0] b);
    int v = 0, p = 1, dg;
    for (int d = 0; d < 6; d++) begin
      dg = int'(b[d*4 +: 4]);
      v += (dg > 9 ? 9 : dg) * p;
      p *= 10;
    end
    return v;
  endfunction
  task automatic check_all(input string tag, input bit exp_ready);
    chk({tag, ".out"}, out, to_bcd(mv));
    chk({tag, ".ready"}, ready, exp_ready);
    chk({tag, ".zero"}, zero, mv == 0);
    chk({tag, ".ovf"}, ovf, mo);
    chk({tag, ".unf"}, unf, mu);
  endtask
  task automatic run_op(input logic [1:0] o, input int s, input logic st, input logic [23:0] v, input bit noise);
    int n, len;
    n = (o[1] || s == 0) ? 1 : s;
    len = n * CD;
    @(negedge clk);
    request = 1'b1; op = o; steps = 4'(s); sat = st; in = v;
    @(posedge clk);
    #1;
    mo = 0; mu = 0;
    request = 1'b0;
    for (int e = 1; e <= len; e++) begin
      if (noise && e < len) begin
        request = 1'($urandom); op = 2'b11; steps = 4'($urandom); sat = 1'($urandom); in = 24'($urandom);
      end else request = 1'b0;
      @(posedge clk);
      #1;
      if (e % CD == 0) begin
        case (o)
          2'b00: if (mv == 999999) begin mo = 1; if (!st) mv = 0; end else mv = mv + 1;
          2'b01: if (mv == 0) begin mu = 1; if (!st) mv = 999999; end else mv = mv - 1;
          2'b10: mv = clamp_val(v);
          default: mv = 0;
        endcase
      end
      check_all("op", e == len);
    end
    request = 1'b0;
  endtask
  initial begin
    #12;
    check_all("reset", 1'b1);
    rst_n = 1'b1;
    run_op(2'b00, 1, 0, 24'h0, 0);
    run_op(2'b10, 0, 0, 24'h000995, 0);
    run_op(2'b00, 7, 0, 24'h0, 0);
    run_op(2'b10, 0, 0, 24'h999998, 0);
    run_op(2'b00, 3, 0, 24'h0, 0);
    run_op(2'b10, 0, 0, 24'h999998, 0);
    run_op(2'b00, 3, 1, 24'h0, 0);
    run_op(2'b11, 0, 0, 24'h0, 0);
    run_op(2'b01, 0, 0, 24'h0, 0);
    run_op(2'b10, 0, 0, 24'h000010, 0);
    run_op(2'b01, 12, 1, 24'h0, 0);
    run_op(2'b00, 5, 0, 24'h0, 1);
    run_op(2'b10, 0, 0, 24'h00C123, 0);
    @(negedge clk);
    request = 1'b1; op = 2'b00; steps = 4'd5; sat = 1'b0;
    @(negedge clk);
    request = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    mv = 0; mo = 0; mu = 0;
    check_all("async_rst", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, 15), 1'($urandom), 24'($urandom), 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
